sc_run_monitor: RTL and testbench

//  Parametrised run-control and observation block for the single-cycle RISC-V CPU (sc_computer).

---
 rtl/sc_mon_pkg.sv | 22 ++
 rtl/sc_trace_ring.sv | 48 ++++
 rtl/sc_run_monitor.sv | 123 ++++++++++++
 tb/tb_sc_run_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_mon_pkg.sv
// Shared encodings for the sc_computer run monitor: FSM states, halt causes
// and the two SYSTEM instructions that end a run.
package sc_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    HC_NONE   = 2'd0,
    HC_LOOP   = 2'd1,
    HC_ECALL  = 2'd2,
    HC_EBREAK = 2'd3
  } halt_cause_t;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/sc_trace_ring.sv
// Push-only circular PC trace with a saturating fill count and a
// combinational read addressed relative to the newest entry (0 = newest).
module sc_trace_ring
  import sc_mon_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic [XLEN-1:0] din,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] dout,
  output logic [AW:0]     cnt
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [XLEN-1:0] ring [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;

  // NOTE: the storage array carries no reset; cnt alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) ring[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (cnt != FULL) cnt <= cnt + (AW + 1)'(1);
    end
  end

  // Power-of-two depth lets the AW-bit subtraction wrap modulo DEPTH.
  assign rd_addr = wr_ptr - AW'(1) - rd_idx;
  assign dout    = ring[rd_addr];

endmodule

// File: rtl/sc_run_monitor.sv
// Run-control and observation block for sc_computer: counts RUN cycles,
// detects halt (self-loop, ECALL, EBREAK) or timeout, traces PCs and signs the run.
module sc_run_monitor
  import sc_mon_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TRACE_DEPTH    = 16,
  parameter int TIMEOUT_CYCLES = 70,
  parameter int HALT_REPEAT    = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         restart,
  input  logic [XLEN-1:0]              pc,
  input  logic [XLEN-1:0]              instr,
  input  logic [XLEN-1:0]              alu,
  input  logic [XLEN-1:0]              mem,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]              trace_pc,
  output logic [$clog2(TRACE_DEPTH):0] trace_cnt,
  output logic [31:0]                  cycle_cnt,
  output logic [XLEN-1:0]              signature,
  output logic [1:0]                   state,
  output logic                         done,
  output logic [1:0]                   halt_cause
);

  localparam int          SW         = $clog2(HALT_REPEAT) + 1;
  localparam logic [SW-1:0] SAME_HALT  = SW'(HALT_REPEAT - 2);
  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  mon_state_t  cur_state, nxt_state;
  halt_cause_t cause_q, hit_cause;
  logic [XLEN-1:0] last_pc;
  logic [SW-1:0]   same_cnt;
  logic            have_last;
  logic            pc_match, timeout_hit, run_step;

  // have_last keeps the first RUN sample from matching the cleared last_pc.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pc_match  = have_last && (pc == last_pc);
    hit_cause = HC_NONE;
    if (instr == XLEN'(INSTR_ECALL))
      hit_cause = HC_ECALL;
    else if (instr == XLEN'(INSTR_EBREAK))
      hit_cause = HC_EBREAK;
    else if (pc_match && (same_cnt == SAME_HALT))
      hit_cause = HC_LOOP;
    timeout_hit = (hit_cause == HC_NONE) && (cycle_cnt == LAST_CYCLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cur_state <= ST_IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (restart) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: if (en) nxt_state = ST_RUN;
        ST_RUN: begin
          if (hit_cause != HC_NONE) nxt_state = ST_HALT;
          else if (timeout_hit)     nxt_state = ST_TIMEOUT;
        end
        default: nxt_state = cur_state;
      endcase
    end
  end

  always_comb begin
    done     = (cur_state == ST_HALT) || (cur_state == ST_TIMEOUT);
    run_step = (cur_state == ST_RUN) && !restart;
  end

  assign state      = cur_state;
  assign halt_cause = cause_q;

  // The terminating sample is still counted and signed, then everything freezes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cycle_cnt <= '0;
      signature <= '0;
      last_pc   <= '0;
      same_cnt  <= '0;
      have_last <= 1'b0;
      cause_q   <= HC_NONE;
    end else if (restart) begin
      cycle_cnt <= '0;
      signature <= '0;
      last_pc   <= '0;
      same_cnt  <= '0;
      have_last <= 1'b0;
      cause_q   <= HC_NONE;
    end else if (run_step) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      signature <= {signature[XLEN-2:0], signature[XLEN-1]} ^ pc ^ alu ^ mem;
      same_cnt  <= pc_match ? same_cnt + SW'(1) : '0;
      last_pc   <= pc;
      have_last <= 1'b1;
      cause_q   <= hit_cause;
    end
  end

  sc_trace_ring #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk    (clk),
    .rst    (clr),
    .clear  (restart),
    .push   (run_step),
    .din    (pc),
    .rd_idx (rd_idx),
    .dout   (trace_pc),
    .cnt    (trace_cnt)
  );

endmodule

// File: tb/tb_sc_run_monitor.sv
// Scoreboard bench for sc_run_monitor: each run pushes its expected end
// state, and a monitor checks it when the DUT raises done.
module tb_sc_run_monitor;
  import sc_mon_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clr, en, restart;
  logic [31:0] pc, instr, alu, mem;
  logic [3:0]  rd_idx;
  logic [31:0] trace_pc, cycle_cnt, signature;
  logic [4:0]  trace_cnt;
  logic [1:0]  state, halt_cause;
  logic        done;

  always #10 clk = ~clk;

  sc_run_monitor dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .restart    (restart),
    .pc         (pc),
    .instr      (instr),
    .alu        (alu),
    .mem        (mem),
    .rd_idx     (rd_idx),
    .trace_pc   (trace_pc),
    .trace_cnt  (trace_cnt),
    .cycle_cnt  (cycle_cnt),
    .signature  (signature),
    .state      (state),
    .done       (done),
    .halt_cause (halt_cause)
  );

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] sig;
    logic [4:0]  tcnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          done_events = 0;
  logic [31:0] pc_v[128], in_v[128], alu_v[128], mem_v[128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model of one run over the vector tables: returns samples consumed and signature.
  task automatic model(input int n, output int m, output logic [31:0] sig);
    logic [31:0] last = '0;
    int          same = 0;
    int          cnt = 0;
    bit          have = 0;
    bit          stop = 0;
    bit          hit;
    sig = '0;
    m   = n;
    for (int i = 0; i < n && !stop; i++) begin
      hit = (in_v[i] == 32'h0000_0073) || (in_v[i] == 32'h0010_0073) ||
            (have && pc_v[i] == last && same == 2);
      if (hit || cnt == 69) begin
        stop = 1;
        m    = i + 1;
      end
      cnt++;
      sig  = {sig[30:0], sig[31]} ^ pc_v[i] ^ alu_v[i] ^ mem_v[i];
      same = (have && pc_v[i] == last) ? same + 1 : 0;
      last = pc_v[i];
      have = 1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic done_d;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_done: got done=1 with no pending run, required done=0");
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_state"},      32'(state),      32'(e.st));
          check({e.tag, "_cause"},      32'(halt_cause), 32'(e.cause));
          check({e.tag, "_cycle_cnt"},  cycle_cnt,       e.cyc);
          check({e.tag, "_signature"},  signature,       e.sig);
          check({e.tag, "_trace_cnt"},  32'(trace_cnt),  32'(e.tcnt));
        end
        done_events++;
      end
      done_d = done;
    end
  end

  task automatic run_prog(input string tag, input int n, input logic [1:0] est,
                          input logic [1:0] ecause, input logic [31:0] ecyc,
                          input logic [4:0] etcnt, input bit chk_first,
                          input logic [31:0] first_sig);
    int          m;
    int          want;
    bit          seen;
    logic [31:0] sig;
    model(n, m, sig);
    exp_q.push_back('{tag, est, ecause, ecyc, sig, etcnt});
    want = done_events + 1;
    @(negedge clk);
    en = 1'b1; pc = '0; instr = NOP; alu = '0; mem = '0;
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      en = 1'b0; pc = pc_v[i]; instr = in_v[i]; alu = alu_v[i]; mem = mem_v[i];
      if (i == m - 1) check({tag, "_pre_done"}, 32'(done), 32'd0);
      @(posedge clk);
      #1;
      if (i == 0 && chk_first) check({tag, "_first_sig"}, signature, first_sig);
      if (i == m - 1) check({tag, "_post_done"}, 32'(done), 32'd1);
    end
    instr = NOP;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = (done_events >= want);
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s_sb_wait: got no done within 10 cycles, required done", tag);
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic chk_trace(input string name, input logic [3:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    #1;
    check(name, trace_pc, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 ns, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    clr = 1'b1; en = 1'b0; restart = 1'b0;
    pc = '0; instr = NOP; alu = '0; mem = '0; rd_idx = '0;
    #5;
    check("rst_state",     32'(state),      32'd0);
    check("rst_done",      32'(done),       32'd0);
    check("rst_cause",     32'(halt_cause), 32'd0);
    check("rst_cycle_cnt", cycle_cnt,       32'd0);
    check("rst_trace_cnt", 32'(trace_cnt),  32'd0);
    check("rst_signature", signature,       32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Asynchronous clear in the middle of a run.
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b0; pc = 32'h40 + 32'(4 * i); alu = 32'(i); mem = 32'hA5A5_0000 + 32'(i);
    end
    @(posedge clk);
    #3;
    check("t1_cycle_before_clr", cycle_cnt, 32'd5);
    clr = 1'b1;
    #1;
    check("t1_clr_state",     32'(state),     32'd0);
    check("t1_clr_cycle_cnt", cycle_cnt,      32'd0);
    check("t1_clr_trace_cnt", 32'(trace_cnt), 32'd0);
    check("t1_clr_signature", signature,      32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Self-loop: pc 4,8,C then 10 held until its 4th sample.
    for (int i = 0; i < 7; i++) begin
      pc_v[i] = (i < 3) ? 32'(4 * (i + 1)) : 32'h10;
      in_v[i] = NOP; alu_v[i] = pc_v[i] + 32'd1; mem_v[i] = 32'(i) << 8;
    end
    run_prog("t2_loop", 7, ST_HALT, HC_LOOP, 32'd7, 5'd7, 1'b0, 32'd0);
    chk_trace("t2_trace0", 4'd0, 32'h10);
    chk_trace("t2_trace4", 4'd4, 32'h0C);
    do_restart();
    #1;
    check("t2_restart_state", 32'(state),      32'd0);
    check("t2_restart_cycle", cycle_cnt,       32'd0);
    check("t2_restart_cause", 32'(halt_cause), 32'd0);
    check("t2_restart_tcnt",  32'(trace_cnt),  32'd0);

    // ECALL on RUN cycle 3, then en ignored while halted.
    for (int i = 0; i < 3; i++) begin
      pc_v[i] = 32'(4 * i); in_v[i] = (i == 2) ? INSTR_ECALL : NOP;
      alu_v[i] = 32'h1000 + 32'(i); mem_v[i] = 32'hF0F0_F0F0 ^ 32'(i);
    end
    run_prog("t3_ecall", 3, ST_HALT, HC_ECALL, 32'd3, 5'd3, 1'b0, 32'd0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("t3_en_in_halt", 32'(state), 32'(ST_HALT));
    en = 1'b0;
    do_restart();

    pc_v[0] = 32'h20; in_v[0] = NOP;         alu_v[0] = 32'h7;  mem_v[0] = 32'h3;
    pc_v[1] = 32'h24; in_v[1] = INSTR_EBREAK; alu_v[1] = 32'h11; mem_v[1] = 32'h0;
    run_prog("t3_ebreak", 2, ST_HALT, HC_EBREAK, 32'd2, 5'd2, 1'b0, 32'd0);
    do_restart();

    // Timeout after 70 RUN cycles with a steadily advancing pc.
    for (int i = 0; i < 70; i++) begin
      pc_v[i] = 32'h100 + 32'(4 * i); in_v[i] = NOP;
      alu_v[i] = 32'(3 * i); mem_v[i] = 32'(i) ^ 32'h55;
    end
    run_prog("t4_timeout", 70, ST_TIMEOUT, HC_NONE, 32'd70, 5'd16, 1'b0, 32'd0);
    chk_trace("t4_trace15", 4'd15, 32'h1D8);
    chk_trace("t4_trace0",  4'd0,  32'h214);
    do_restart();

    // ECALL on the timeout sample: halt wins.
    in_v[69] = INSTR_ECALL;
    run_prog("t5_ecall_vs_to", 70, ST_HALT, HC_ECALL, 32'd70, 5'd16, 1'b0, 32'd0);
    do_restart();
    @(negedge clk);
    restart = 1'b1; en = 1'b1;
    @(posedge clk);
    #1;
    check("t5_restart_beats_en", 32'(state), 32'd0);
    check("t5_idle_cycle_cnt",   cycle_cnt,  32'd0);
    @(negedge clk);
    restart = 1'b0; en = 1'b0;

    // Signature: first sample pc=4, alu=1, mem=0 gives 5, then a short program ending in ECALL.
    for (int i = 0; i < 7; i++) begin
      pc_v[i] = 32'(4 * (i + 1)); in_v[i] = (i == 6) ? INSTR_ECALL : NOP;
      alu_v[i] = (i == 0) ? 32'd1 : 32'hDEAD_0000 + 32'(i * 17);
      mem_v[i] = (i == 0) ? 32'd0 : 32'h0BAD_F00D ^ (32'(i) << 12);
    end
    run_prog("t6_sig", 7, ST_HALT, HC_ECALL, 32'd7, 5'd7, 1'b1, 32'd5);
    chk_trace("t6_trace6", 4'd6, 32'h4);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
